// File: rtl/inst_fetch_if.sv
// inst_fetch_if: imem request/response and decode handshake bundle.
// master = fetch stage, slave = memory plus decode side.
interface inst_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    modport master (
        output imem_req_o, imem_addr_o,
        output inst_valid_o, inst_o, inst_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        input  inst_valid_o, inst_o, inst_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output inst_ready_i
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC, imem requests, PC queue and instruction buffer.
// Redirects flush the buffer and drain stale in-flight responses.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    inst_fetch_if.master fetch_io
);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CWP = CW + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   CREDITS  = CWP'(FIFO_DEPTH);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [31:0]   pcq_q [FIFO_DEPTH];
    logic [PW-1:0] pcq_wp_q, pcq_rp_q;
    logic [31:0]   finst_q [FIFO_DEPTH];
    logic [31:0]   fpc_q [FIFO_DEPTH];
    logic [PW-1:0] fwp_q, frp_q;
    logic [31:0]   last_inst_q, last_pc_q;
    logic          req, grant, rsp, drop, push, pop, fnempty;
    logic          unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // request credit and per-cycle transfer events
    always_comb begin
        fnempty = (fcnt_q != '0);
        req     = (state_q == S_RUN) && !redirect_i
                  && (({1'b0, outst_q} + {1'b0, fcnt_q}) < CREDITS);
        grant   = req && fetch_io.imem_gnt_i;
        rsp     = fetch_io.imem_rvalid_i && (outst_q != '0);
        drop    = rsp && (redirect_i || (disc_q != '0));
        push    = rsp && !drop;
        pop     = fnempty && fetch_io.inst_ready_i && !redirect_i;
    end

    // next fetch PC, counters and FSM
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i)
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
        else if (grant)
            fetch_pc_d = fetch_pc_q + 32'd4;
        outst_d = outst_q + CW'(grant) - CW'(rsp);
        disc_d  = disc_q;
        if (redirect_i)
            disc_d = outst_q - CW'(rsp);
        else if (drop)
            disc_d = disc_q - CW'(1);
        fcnt_d  = redirect_i ? '0 : fcnt_q + CW'(push) - CW'(pop);
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redirect_i && disc_d != '0) state_d = S_DRAIN;
            S_DRAIN: if (disc_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    // state, fetch PC and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            disc_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // PC queue: address of each in-flight request, in grant order
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcq_wp_q <= '0;
            pcq_rp_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) pcq_q[i] <= '0;
        end else begin
            if (grant) begin
                pcq_q[pcq_wp_q] <= fetch_pc_q;
                pcq_wp_q        <= nxt(pcq_wp_q);
            end
            if (rsp) pcq_rp_q <= nxt(pcq_rp_q);
        end
    end

    // instruction buffer; a redirect empties it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwp_q <= '0;
            frp_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                finst_q[i] <= '0;
                fpc_q[i]   <= '0;
            end
        end else if (redirect_i) begin
            fwp_q <= '0;
            frp_q <= '0;
        end else begin
            if (push) begin
                finst_q[fwp_q] <= fetch_io.imem_rdata_i;
                fpc_q[fwp_q]   <= pcq_q[pcq_rp_q];
                fwp_q          <= nxt(fwp_q);
            end
            if (pop) frp_q <= nxt(frp_q);
        end
    end

    // remember the head so outputs hold while the buffer is empty
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_inst_q <= '0;
            last_pc_q   <= '0;
        end else if (fnempty) begin
            last_inst_q <= finst_q[frp_q];
            last_pc_q   <= fpc_q[frp_q];
        end
    end

    assign fetch_io.imem_req_o   = req;
    assign fetch_io.imem_addr_o  = fetch_pc_q;
    assign fetch_io.inst_valid_o = fnempty && !redirect_i;
    assign fetch_io.inst_o       = fnempty ? finst_q[frp_q] : last_inst_q;
    assign fetch_io.inst_pc_o    = fnempty ? fpc_q[frp_q] : last_pc_q;
endmodule
